// File: rtl/nts_tx_arbiter.sv
// Round-robin arbiter sharing one TX extractor between ENGINES NTS engine TX FIFOs.
// Optional per-engine packet counters when NTS_TX_ARBITER_STATS_EN is defined.
module nts_tx_arbiter #(
    parameter int ENGINES        = 4,
    parameter int MAC_DATA_WIDTH = 64,
    parameter int IDX_WIDTH      = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
    input  logic                                i_clk,
    input  logic                                i_areset,

    input  logic [ENGINES-1:0]                  i_engine_packet_available,
    output logic [ENGINES-1:0]                  o_engine_packet_read,
    input  logic [ENGINES-1:0]                  i_engine_fifo_empty,
    output logic [ENGINES-1:0]                  o_engine_fifo_rd_start,
    input  logic [ENGINES-1:0]                  i_engine_fifo_rd_valid,
    input  logic [MAC_DATA_WIDTH*ENGINES-1:0]   i_engine_fifo_rd_data,
    input  logic [4*ENGINES-1:0]                i_engine_bytes_last_word,

    output logic                                o_extractor_packet_available,
    input  logic                                i_extractor_packet_read,
    output logic                                o_extractor_fifo_empty,
    input  logic                                i_extractor_fifo_rd_start,
    output logic                                o_extractor_fifo_rd_valid,
    output logic [MAC_DATA_WIDTH-1:0]           o_extractor_fifo_rd_data,
    output logic [3:0]                          o_extractor_bytes_last_word,

    output logic                                o_grant_valid,
    output logic [IDX_WIDTH-1:0]                o_grant_index
`ifdef NTS_TX_ARBITER_STATS_EN
    ,
    output logic [32*ENGINES-1:0]               o_stats_packets
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [IDX_WIDTH:0]   ENG_CNT  = (IDX_WIDTH+1)'(ENGINES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ENGINES - 1);

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic                 grant_active;
    logic                 pick_found;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [IDX_WIDTH:0]   cand;

    logic                      sel_avail;
    logic                      sel_empty;
    logic                      sel_valid;
    logic [MAC_DATA_WIDTH-1:0] sel_data;
    logic [3:0]                sel_blw;

    assign grant_active = (state_q == ST_GRANT);

    // First available engine at or after rr_ptr, searching with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < ENGINES; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(i);
            if (cand >= ENG_CNT) begin
                cand = cand - ENG_CNT;
            end
            if (!pick_found && i_engine_packet_available[cand[IDX_WIDTH-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // Signals of the engine addressed by the grant index, before no-grant gating.
    always_comb begin
        sel_avail = 1'b0;
        sel_empty = 1'b1;
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_blw   = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (grant_idx_q == IDX_WIDTH'(k)) begin
                sel_avail = i_engine_packet_available[k];
                sel_empty = i_engine_fifo_empty[k];
                sel_valid = i_engine_fifo_rd_valid[k];
                sel_data  = i_engine_fifo_rd_data[k*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
                sel_blw   = i_engine_bytes_last_word[k*4 +: 4];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // A grant lasts until the extractor pulses packet_read or the engine withdraws
    // available (abort); either way the pointer moves past the granted engine.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = pick_idx;
                end
            end
            ST_GRANT: begin
                if (i_extractor_packet_read || !sel_avail) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes (packet_read, rd_start) are single-cycle pulses forwarded combinationally
    // to the granted engine only while in GRANT; everywhere else they are dropped.
    always_comb begin
        o_grant_valid                = grant_active;
        o_grant_index                = grant_idx_q;
        o_extractor_packet_available = grant_active & sel_avail;
        o_extractor_fifo_empty       = grant_active ? sel_empty : 1'b1;
        o_extractor_fifo_rd_valid    = grant_active & sel_valid;
        o_extractor_fifo_rd_data     = grant_active ? sel_data : '0;
        o_extractor_bytes_last_word  = grant_active ? sel_blw : 4'd0;
        o_engine_packet_read         = '0;
        o_engine_fifo_rd_start       = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (grant_active && (grant_idx_q == IDX_WIDTH'(k))) begin
                o_engine_packet_read[k]   = i_extractor_packet_read;
                o_engine_fifo_rd_start[k] = i_extractor_fifo_rd_start;
            end
        end
    end

`ifdef NTS_TX_ARBITER_STATS_EN
    logic [31:0] stats_q [ENGINES];

    // Only forwarded reads count, so aborted grants leave the counters untouched.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            for (int k = 0; k < ENGINES; k++) begin
                stats_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < ENGINES; k++) begin
                if (o_engine_packet_read[k]) begin
                    stats_q[k] <= stats_q[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        o_stats_packets = '0;
        for (int k = 0; k < ENGINES; k++) begin
            o_stats_packets[k*32 +: 32] = stats_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Directed testbench for nts_tx_arbiter (ENGINES=4, 64-bit data).
// Stats counters are exercised when NTS_TX_ARBITER_STATS_EN is defined.
module tb_nts_tx_arbiter;

    localparam int ENGINES = 4;
    localparam int W       = 64;
    localparam int IW      = 2;

    logic                   i_clk = 1'b0;
    logic                   i_areset = 1'b1;
    logic [ENGINES-1:0]     i_engine_packet_available;
    logic [ENGINES-1:0]     o_engine_packet_read;
    logic [ENGINES-1:0]     i_engine_fifo_empty;
    logic [ENGINES-1:0]     o_engine_fifo_rd_start;
    logic [ENGINES-1:0]     i_engine_fifo_rd_valid;
    logic [W*ENGINES-1:0]   i_engine_fifo_rd_data;
    logic [4*ENGINES-1:0]   i_engine_bytes_last_word;
    logic                   o_extractor_packet_available;
    logic                   i_extractor_packet_read;
    logic                   o_extractor_fifo_empty;
    logic                   i_extractor_fifo_rd_start;
    logic                   o_extractor_fifo_rd_valid;
    logic [W-1:0]           o_extractor_fifo_rd_data;
    logic [3:0]             o_extractor_bytes_last_word;
    logic                   o_grant_valid;
    logic [IW-1:0]          o_grant_index;
`ifdef NTS_TX_ARBITER_STATS_EN
    logic [32*ENGINES-1:0]  o_stats_packets;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 i_clk = ~i_clk;

    nts_tx_arbiter #(
        .ENGINES(ENGINES),
        .MAC_DATA_WIDTH(W)
    ) dut (
        .i_clk(i_clk),
        .i_areset(i_areset),
        .i_engine_packet_available(i_engine_packet_available),
        .o_engine_packet_read(o_engine_packet_read),
        .i_engine_fifo_empty(i_engine_fifo_empty),
        .o_engine_fifo_rd_start(o_engine_fifo_rd_start),
        .i_engine_fifo_rd_valid(i_engine_fifo_rd_valid),
        .i_engine_fifo_rd_data(i_engine_fifo_rd_data),
        .i_engine_bytes_last_word(i_engine_bytes_last_word),
        .o_extractor_packet_available(o_extractor_packet_available),
        .i_extractor_packet_read(i_extractor_packet_read),
        .o_extractor_fifo_empty(o_extractor_fifo_empty),
        .i_extractor_fifo_rd_start(i_extractor_fifo_rd_start),
        .o_extractor_fifo_rd_valid(o_extractor_fifo_rd_valid),
        .o_extractor_fifo_rd_data(o_extractor_fifo_rd_data),
        .o_extractor_bytes_last_word(o_extractor_bytes_last_word),
        .o_grant_valid(o_grant_valid),
        .o_grant_index(o_grant_index)
`ifdef NTS_TX_ARBITER_STATS_EN
        ,
        .o_stats_packets(o_stats_packets)
`endif
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        i_engine_packet_available = '0;
        i_engine_fifo_empty       = '1;
        i_engine_fifo_rd_valid    = '0;
        i_engine_fifo_rd_data     = '0;
        i_engine_bytes_last_word  = '0;
        i_extractor_packet_read   = 1'b0;
        i_extractor_fifo_rd_start = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        i_areset = 1'b1;
        next_cycle();
        next_cycle();
        i_areset = 1'b0;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        settle();
        while (!o_grant_valid && cycles < 12) begin
            next_cycle();
            settle();
            cycles++;
        end
    endtask

    task automatic test_reset();
        i_areset                  = 1'b1;
        i_engine_packet_available = 4'hF;
        i_engine_fifo_empty       = 4'h0;
        i_engine_fifo_rd_valid    = 4'hF;
        i_engine_fifo_rd_data     = {4{64'h1111_2222_3333_4444}};
        i_engine_bytes_last_word  = 16'hFFFF;
        i_extractor_packet_read   = 1'b1;
        i_extractor_fifo_rd_start = 1'b1;
        next_cycle();
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_grant_valid: got %0b expected 0", o_grant_valid); end
        vec_cnt++; if (o_grant_index !== 2'd0) begin err_cnt++; $display("FAIL reset_grant_index: got %0d expected 0", o_grant_index); end
        vec_cnt++; if (o_extractor_packet_available !== 1'b0) begin err_cnt++; $display("FAIL reset_ext_avail: got %0b expected 0", o_extractor_packet_available); end
        vec_cnt++; if (o_extractor_fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL reset_ext_empty: got %0b expected 1", o_extractor_fifo_empty); end
        vec_cnt++; if (o_extractor_fifo_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_ext_valid: got %0b expected 0", o_extractor_fifo_rd_valid); end
        vec_cnt++; if (o_extractor_fifo_rd_data !== 64'd0) begin err_cnt++; $display("FAIL reset_ext_data: got %h expected 0", o_extractor_fifo_rd_data); end
        vec_cnt++; if (o_extractor_bytes_last_word !== 4'd0) begin err_cnt++; $display("FAIL reset_ext_blw: got %0d expected 0", o_extractor_bytes_last_word); end
        vec_cnt++; if (o_engine_packet_read !== 4'b0000) begin err_cnt++; $display("FAIL reset_eng_pkt_read: got %b expected 0000", o_engine_packet_read); end
        vec_cnt++; if (o_engine_fifo_rd_start !== 4'b0000) begin err_cnt++; $display("FAIL reset_eng_rd_start: got %b expected 0000", o_engine_fifo_rd_start); end
        i_extractor_packet_read   = 1'b0;
        i_extractor_fifo_rd_start = 1'b0;
        i_areset                  = 1'b0;
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL release_idle_valid: got %0b expected 0", o_grant_valid); end
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1) begin err_cnt++; $display("FAIL release_grant_valid: got %0b expected 1", o_grant_valid); end
        vec_cnt++; if (o_grant_index !== 2'd0) begin err_cnt++; $display("FAIL release_grant_index: got %0d expected 0", o_grant_index); end
        vec_cnt++; if (o_extractor_packet_available !== 1'b1) begin err_cnt++; $display("FAIL release_ext_avail: got %0b expected 1", o_extractor_packet_available); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        i_engine_packet_available = 4'b1010;
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL rr_first_grant: got v=%0b idx=%0d expected v=1 idx=1", o_grant_valid, o_grant_index); end
        i_extractor_packet_read = 1'b1;
        settle();
        vec_cnt++; if (o_engine_packet_read !== 4'b0010) begin err_cnt++; $display("FAIL rr_read_route1: got %b expected 0010", o_engine_packet_read); end
        next_cycle();
        i_extractor_packet_read   = 1'b0;
        i_engine_packet_available = 4'b1000;
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_release_valid: got %0b expected 0", o_grant_valid); end
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_idle_valid: got %0b expected 0", o_grant_valid); end
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd3) begin err_cnt++; $display("FAIL rr_second_grant: got v=%0b idx=%0d expected v=1 idx=3", o_grant_valid, o_grant_index); end
        i_extractor_packet_read = 1'b1;
        settle();
        vec_cnt++; if (o_engine_packet_read !== 4'b1000) begin err_cnt++; $display("FAIL rr_read_route3: got %b expected 1000", o_engine_packet_read); end
        next_cycle();
        i_extractor_packet_read   = 1'b0;
        i_engine_packet_available = 4'b1010;
        next_cycle();
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL rr_wrap_grant: got v=%0b idx=%0d expected v=1 idx=1", o_grant_valid, o_grant_index); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int gap;
        apply_reset();
        i_engine_packet_available = 4'hF;
        next_cycle();
        for (int p = 0; p < 8; p++) begin
            wait_grant(gap);
            vec_cnt++; if (o_grant_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_timeout: packet %0d got no grant within %0d cycles", p, gap); end
            vec_cnt++; if (o_grant_index !== IW'(p % 4)) begin err_cnt++; $display("FAIL b2b_index: packet %0d got %0d expected %0d", p, o_grant_index, p % 4); end
            vec_cnt++; if (gap !== ((p == 0) ? 0 : 2)) begin err_cnt++; $display("FAIL b2b_gap: packet %0d got %0d idle cycles expected %0d", p, gap, (p == 0) ? 0 : 2); end
            i_extractor_packet_read = 1'b1;
            settle();
            vec_cnt++; if (o_engine_packet_read !== (4'b0001 << (p % 4))) begin err_cnt++; $display("FAIL b2b_read_route: packet %0d got %b expected %b", p, o_engine_packet_read, 4'b0001 << (p % 4)); end
            next_cycle();
            i_extractor_packet_read = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_data_path();
        apply_reset();
        i_engine_packet_available = 4'b0100;
        i_engine_fifo_rd_data     = {64'h3333_3333_3333_3333, 64'hDEADBEEF_00C0FFEE,
                                     64'h1111_1111_1111_1111, 64'h0000_0000_0000_0ABC};
        i_engine_fifo_rd_valid    = 4'b1011;
        i_engine_fifo_empty       = 4'b0000;
        settle();
        vec_cnt++; if (o_extractor_fifo_rd_data !== 64'd0 || o_extractor_fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL dp_nogrant_gate: got data=%h empty=%0b expected 0/1", o_extractor_fifo_rd_data, o_extractor_fifo_empty); end
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd2) begin err_cnt++; $display("FAIL dp_grant: got v=%0b idx=%0d expected v=1 idx=2", o_grant_valid, o_grant_index); end
        i_engine_fifo_rd_valid   = 4'b0100;
        i_engine_fifo_empty      = 4'b1011;
        i_engine_bytes_last_word = {4'h1, 4'h5, 4'h2, 4'h3};
        settle();
        vec_cnt++; if (o_extractor_fifo_rd_data !== 64'hDEADBEEF_00C0FFEE) begin err_cnt++; $display("FAIL dp_data: got %h expected deadbeef00c0ffee", o_extractor_fifo_rd_data); end
        vec_cnt++; if (o_extractor_fifo_rd_valid !== 1'b1) begin err_cnt++; $display("FAIL dp_valid: got %0b expected 1", o_extractor_fifo_rd_valid); end
        vec_cnt++; if (o_extractor_fifo_empty !== 1'b0) begin err_cnt++; $display("FAIL dp_empty: got %0b expected 0", o_extractor_fifo_empty); end
        vec_cnt++; if (o_extractor_bytes_last_word !== 4'h5) begin err_cnt++; $display("FAIL dp_blw: got %0d expected 5", o_extractor_bytes_last_word); end
        i_extractor_fifo_rd_start = 1'b1;
        settle();
        vec_cnt++; if (o_engine_fifo_rd_start !== 4'b0100) begin err_cnt++; $display("FAIL dp_rd_start_route: got %b expected 0100", o_engine_fifo_rd_start); end
        i_extractor_fifo_rd_start = 1'b0;
        i_engine_fifo_rd_valid    = 4'b1011;
        settle();
        vec_cnt++; if (o_extractor_fifo_rd_valid !== 1'b0) begin err_cnt++; $display("FAIL dp_valid_follow: got %0b expected 0", o_extractor_fifo_rd_valid); end
        i_extractor_packet_read = 1'b1;
        next_cycle();
        i_extractor_packet_read   = 1'b0;
        i_engine_packet_available = 4'b0000;
        settle();
        vec_cnt++; if (o_extractor_fifo_rd_data !== 64'd0 || o_extractor_bytes_last_word !== 4'd0) begin err_cnt++; $display("FAIL dp_release_gate: got data=%h blw=%0d expected 0/0", o_extractor_fifo_rd_data, o_extractor_bytes_last_word); end
        clear_inputs();
    endtask

    task automatic test_abort();
        apply_reset();
        i_engine_packet_available = 4'b0011;
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd0) begin err_cnt++; $display("FAIL abort_grant: got v=%0b idx=%0d expected v=1 idx=0", o_grant_valid, o_grant_index); end
        i_engine_packet_available = 4'b0010;
        settle();
        vec_cnt++; if (o_extractor_packet_available !== 1'b0 || o_engine_packet_read !== 4'b0000) begin err_cnt++; $display("FAIL abort_drop: got avail=%0b read=%b expected 0/0000", o_extractor_packet_available, o_engine_packet_read); end
        next_cycle();
        i_engine_packet_available = 4'b0011;
        i_extractor_packet_read   = 1'b1;
        i_extractor_fifo_rd_start = 1'b1;
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_release_valid: got %0b expected 0", o_grant_valid); end
        vec_cnt++; if (o_engine_packet_read !== 4'b0000 || o_engine_fifo_rd_start !== 4'b0000) begin err_cnt++; $display("FAIL abort_strobe_ignored: got read=%b start=%b expected 0000/0000", o_engine_packet_read, o_engine_fifo_rd_start); end
        next_cycle();
        i_extractor_packet_read   = 1'b0;
        i_extractor_fifo_rd_start = 1'b0;
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_idle_valid: got %0b expected 0", o_grant_valid); end
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL abort_ptr_advance: got v=%0b idx=%0d expected v=1 idx=1", o_grant_valid, o_grant_index); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_engine_packet_available = 4'b0010;
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL mid_first_grant: got %0d expected 1", o_grant_index); end
        i_extractor_packet_read = 1'b1;
        next_cycle();
        i_extractor_packet_read   = 1'b0;
        i_engine_packet_available = 4'b0110;
        next_cycle();
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd2) begin err_cnt++; $display("FAIL mid_second_grant: got v=%0b idx=%0d expected v=1 idx=2", o_grant_valid, o_grant_index); end
        i_areset = 1'b1;
        #1;
        vec_cnt++; if (o_grant_valid !== 1'b0 || o_extractor_packet_available !== 1'b0 || o_extractor_fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL mid_async_drop: got v=%0b avail=%0b empty=%0b expected 0/0/1", o_grant_valid, o_extractor_packet_available, o_extractor_fifo_empty); end
        next_cycle();
        i_areset = 1'b0;
        next_cycle();
        settle();
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL mid_ptr_cleared: got v=%0b idx=%0d expected v=1 idx=1", o_grant_valid, o_grant_index); end
        clear_inputs();
    endtask

`ifdef NTS_TX_ARBITER_STATS_EN
    task automatic test_stats();
        int c;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            i_engine_packet_available = 4'b0010;
            wait_grant(c);
            vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd1) begin err_cnt++; $display("FAIL stats_grant1: packet %0d got v=%0b idx=%0d expected v=1 idx=1", p, o_grant_valid, o_grant_index); end
            i_extractor_packet_read = 1'b1;
            next_cycle();
            i_extractor_packet_read   = 1'b0;
            i_engine_packet_available = 4'b0000;
        end
        i_engine_packet_available = 4'b0100;
        wait_grant(c);
        vec_cnt++; if (o_grant_valid !== 1'b1 || o_grant_index !== 2'd2) begin err_cnt++; $display("FAIL stats_grant2: got v=%0b idx=%0d expected v=1 idx=2", o_grant_valid, o_grant_index); end
        i_engine_packet_available = 4'b0000;
        next_cycle();
        next_cycle();
        next_cycle();
        settle();
        vec_cnt++; if (o_stats_packets[63:32] !== 32'd3) begin err_cnt++; $display("FAIL stats_engine1: got %0d expected 3", o_stats_packets[63:32]); end
        vec_cnt++; if (o_stats_packets[95:64] !== 32'd0) begin err_cnt++; $display("FAIL stats_engine2: got %0d expected 0", o_stats_packets[95:64]); end
        vec_cnt++; if (o_stats_packets[31:0] !== 32'd0) begin err_cnt++; $display("FAIL stats_engine0: got %0d expected 0", o_stats_packets[31:0]); end
        clear_inputs();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_data_path();
        test_abort();
        test_reset_mid();
`ifdef NTS_TX_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
